// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
//   fetch_state_t   - fetch FSM states (IDLE, FETCH, HALTED)
//   fetch_entry_t   - queue payload {pc, inst}
//   FETCH_Q_DEPTH   - instruction queue depth
//   DEFAULT_HALT_OP - opcode (inst[15:12]) that stops fetching
package fetch_pkg;

  localparam int unsigned XLEN          = 16;
  localparam int unsigned FETCH_Q_DEPTH = 2;
  localparam int unsigned CNT_W         = 2;

  localparam logic [3:0] DEFAULT_HALT_OP = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry synchronous FIFO between memory return and decode.
// Entry 0 is always the head, so head/valid come straight from flops and
// empty slots are held at zero. Flush overrides push and pop.
//   clk, reset  - clock, synchronous active-high reset
//   push, push_data - enqueue (ignored when full)
//   pop         - dequeue head (ignored when empty)
//   flush       - discard all entries
//   head        - head entry, zero when empty
//   valid       - queue not empty
//   count       - number of entries held
module fetch_queue
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  input  logic               flush,
  output fetch_entry_t       head,
  output logic               valid,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     slot1;
  logic             push_ok;
  logic             pop_ok;
  logic [CNT_W-1:0] count_next;

  assign push_ok    = push && (count < CNT_W'(FETCH_Q_DEPTH));
  assign pop_ok     = pop && (count != '0);
  assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop_ok);

  // Shift-style storage: pops move slot1 into the head.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      slot1 <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      count <= count_next;
      valid <= (count_next != '0);
      unique case ({push_ok, pop_ok})
        2'b10: begin
          if (count == '0) head  <= push_data;
          else             slot1 <= push_data;
        end
        2'b01: begin
          head  <= slot1;
          slot1 <= '0;
        end
        2'b11: begin
          if (count == CNT_W'(1)) begin
            head <= push_data;
          end else begin
            head  <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Issues imem reads at pc, queues
// returned words toward decode and computes next_pc for the PC register.
// Optional feature macro: FETCH_PERF_EN enables fetch_count/flush_count.
//   clk, reset                   - clock, synchronous active-high reset
//   pc / next_pc                 - PC register value in / next value out
//   imem_req, imem_addr          - memory read request and word address
//   imem_ack, imem_rdata         - memory response
//   redirect_valid/target        - taken branch: flush and refetch
//   inst_valid, inst, inst_pc    - queue head toward decode
//   inst_ready                   - decode accepts head
//   fetch_count, flush_count     - performance counters (0 when disabled)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [3:0] HALT_OP = DEFAULT_HALT_OP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic [XLEN-1:0] fetch_count,
  output logic [XLEN-1:0] flush_count
);

  fetch_state_t     state;
  fetch_entry_t     head;
  fetch_entry_t     push_data;
  logic             accept;
  logic             pop;
  logic             is_halt;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] q_count_next;
  logic             room_next;

  assign imem_addr = pc;
  assign accept    = imem_req && imem_ack && !redirect_valid;
  assign pop       = inst_valid && inst_ready && !redirect_valid;
  assign is_halt   = (imem_rdata[15:12] == HALT_OP);
  assign push_data = '{pc: pc, inst: imem_rdata};

  // Queue occupancy after this edge; lets imem_req be a registered output.
  assign q_count_next = redirect_valid ? '0
                      : q_count + CNT_W'(accept) - CNT_W'(pop);
  assign room_next    = (q_count_next < CNT_W'(FETCH_Q_DEPTH));

  // PC mux: redirect beats sequential advance; otherwise hold.
  always_comb begin
    next_pc = pc;
    if (reset)               next_pc = '0;
    else if (redirect_valid) next_pc = redirect_target;
    else if (accept)         next_pc = pc + XLEN'(1);
  end

  // Fetch FSM with registered request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      imem_req <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= room_next;
        end
        FETCH: begin
          if (accept && is_halt) begin
            state    <= HALTED;
            imem_req <= 1'b0;
          end else begin
            imem_req <= room_next;
          end
        end
        HALTED: begin
          if (redirect_valid) begin
            state    <= FETCH;
            imem_req <= room_next;
          end else begin
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  fetch_queue u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .valid     (inst_valid),
    .count     (q_count)
  );

  assign inst    = head.inst;
  assign inst_pc = head.pc;

`ifdef FETCH_PERF_EN
  // Wrapping event counters; flushes add the number of entries discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (accept)         fetch_count <= fetch_count + XLEN'(1);
      if (redirect_valid) flush_count <= flush_count + XLEN'(q_count);
    end
  end
`else
  assign fetch_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit with a PC
// register and instruction memory model (word = addr ^ 0x1000, optional
// halt word at a chosen address).
module tb_fetch_unit;

  localparam int S_IDLE   = 0;
  localparam int S_FETCH  = 1;
  localparam int S_HALTED = 2;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] next_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic [15:0] fetch_count;
  logic [15:0] flush_count;

  logic        halt_en;
  logic [15:0] halt_addr;

  int checks   = 0;
  int failures = 0;

  ent_t        exp_q[$];
  int          m_state;
  logic [15:0] m_pc;
  logic [15:0] m_fc;
  logic [15:0] m_flc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .next_pc         (next_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .inst_ready      (inst_ready),
    .fetch_count     (fetch_count),
    .flush_count     (flush_count)
  );

  // Program counter register closing the loop.
  always_ff @(posedge clk) begin
    if (reset) pc <= 16'h0000;
    else       pc <= next_pc;
  end

  function automatic logic [15:0] memf(input logic [15:0] a, input logic hen,
                                       input logic [15:0] haddr);
    if (hen && a == haddr) return 16'hF123;
    return a ^ 16'h1000;
  endfunction

  assign imem_rdata = memf(pc, halt_en, halt_addr);

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every instruction decode takes against the scoreboard.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && inst_valid && inst_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_inst: got pc %h inst %h, none expected",
                   inst_pc, inst);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", 32'(inst_pc), 32'(e.pc));
          check("inst", 32'(inst), 32'(e.inst));
        end
      end
    end
  end

  // One clock of stimulus plus reference-model step.
  task automatic cycle(input bit rst, input bit ack, input bit rdy,
                       input bit rv, input logic [15:0] tgt);
    int          sz;
    bit          m_req;
    bit          acc;
    bit          halt;
    logic [15:0] w;
    logic [15:0] exp_next;
    @(negedge clk);
    reset           = rst;
    imem_ack        = ack;
    inst_ready      = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    #1;
    sz    = exp_q.size();
    m_req = (m_state == S_FETCH) && (sz < 2);
    acc   = m_req && ack && !rv;
    w     = memf(m_pc, halt_en, halt_addr);
    halt  = acc && (w[15:12] == 4'hF);
    if (rst)      exp_next = 16'h0000;
    else if (rv)  exp_next = tgt;
    else if (acc) exp_next = m_pc + 16'd1;
    else          exp_next = m_pc;

    check("pc", 32'(pc), 32'(m_pc));
    check("imem_req", 32'(imem_req), 32'(m_req));
    check("imem_addr", 32'(imem_addr), 32'(m_pc));
    check("inst_valid", 32'(inst_valid), 32'(sz != 0));
    check("next_pc", 32'(next_pc), 32'(exp_next));
    if (sz == 0) begin
      check("inst_empty", 32'(inst), 32'h0);
      check("inst_pc_empty", 32'(inst_pc), 32'h0);
    end
`ifdef FETCH_PERF_EN
    check("fetch_count", 32'(fetch_count), 32'(m_fc));
    check("flush_count", 32'(flush_count), 32'(m_flc));
`else
    check("fetch_count", 32'(fetch_count), 32'h0);
    check("flush_count", 32'(flush_count), 32'h0);
`endif
    #2;
    if (rst) begin
      exp_q.delete();
      m_state = S_IDLE;
      m_pc    = 16'h0000;
      m_fc    = 16'h0000;
      m_flc   = 16'h0000;
    end else begin
      if (rv) begin
        m_flc = m_flc + 16'(sz);
        exp_q.delete();
      end else if (acc) begin
        exp_q.push_back(ent_t'{pc: m_pc, inst: w});
        m_fc = m_fc + 16'd1;
      end
      case (m_state)
        S_IDLE:   m_state = S_FETCH;
        S_FETCH:  if (halt) m_state = S_HALTED;
        S_HALTED: if (rv) m_state = S_FETCH;
        default:  m_state = S_IDLE;
      endcase
      m_pc = exp_next;
    end
  endtask

  initial begin
    reset           = 1'b1;
    imem_ack        = 1'b0;
    inst_ready      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 16'h0000;
    halt_en         = 1'b0;
    halt_addr       = 16'h0000;
    m_state         = S_IDLE;
    m_pc            = 16'h0000;
    m_fc            = 16'h0000;
    m_flc           = 16'h0000;
    repeat (2) @(posedge clk);

    // Reset state
    cycle(1, 0, 0, 0, 16'h0);
    cycle(1, 0, 0, 0, 16'h0);

    // Zero-wait streaming from PC 0
    repeat (12) cycle(0, 1, 1, 0, 16'h0);

    // Wait states at PC 5
    cycle(0, 1, 1, 1, 16'h0005);
    repeat (3) cycle(0, 0, 1, 0, 16'h0);
    repeat (3) cycle(0, 1, 1, 0, 16'h0);

    // Decode back-pressure, then drain
    repeat (4) cycle(0, 1, 0, 0, 16'h0);
    repeat (6) cycle(0, 1, 1, 0, 16'h0);

    // Queue holding 7,8 flushed by redirect with a concurrent ack
    cycle(0, 1, 0, 1, 16'h0007);
    repeat (2) cycle(0, 1, 0, 0, 16'h0);
    cycle(0, 1, 0, 1, 16'h0040);
    repeat (4) cycle(0, 1, 1, 0, 16'h0);

    // Halt word at 0x0010, then resume via redirect to 0
    halt_en   = 1'b1;
    halt_addr = 16'h0010;
    cycle(0, 1, 1, 1, 16'h000E);
    repeat (8) cycle(0, 1, 1, 0, 16'h0);
    cycle(0, 1, 1, 1, 16'h0000);
    repeat (4) cycle(0, 1, 1, 0, 16'h0);
    halt_en = 1'b0;

    // PC wrap at 0xFFFF
    cycle(0, 1, 1, 1, 16'hFFFE);
    repeat (5) cycle(0, 1, 1, 0, 16'h0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 8,
            16'($urandom));
    end

    // Reset mid-stream
    cycle(0, 1, 1, 1, 16'h0100);
    repeat (3) cycle(0, 1, 1, 0, 16'h0);
    cycle(1, 1, 1, 0, 16'h0);
    repeat (5) cycle(0, 1, 1, 0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the 16-bit processor. It consumes the current `PC` from the program counter register, drives the instruction memory request, buffers returned instructions in a 2-entry queue toward decode, and computes `next_pc` back into the program counter. This closes the PC loop: the program counter stores the value, and this block decides what it becomes. Handles sequential advance, wait states, branch redirects and halt.

## Interface
- `HALT_OP`, default `4'hF`: opcode (inst[15:12]) that stops fetching.
- `clk` input 1: clock, rising edge.
- `reset` input 1: reset is synchronous and active-high. The same net also drives the program counter register.
- `pc` input 16: current PC from the program counter register.
- `next_pc` output 16: value loaded into the program counter register on the next edge.
- `imem_req` output 1: instruction read request. Level signal.
- `imem_addr` output 16: word address; always equals `pc`.
- `imem_ack` input 1: `imem_rdata` is valid for `imem_addr` this cycle. Wait states are allowed.
- `imem_rdata` input 16: instruction word.
- `redirect_valid` input 1: branch or jump taken; flush and refetch.
- `redirect_target` input 16: new fetch address.
- `inst_valid` output 1: queue head valid toward decode.
- `inst` output 16: queue head instruction.
- `inst_pc` output 16: address of `inst`.
- `inst_ready` input 1: decode accepts the head this cycle.
- `fetch_count` output 16: instructions accepted from memory (see Configuration).
- `flush_count` output 16: queue entries discarded by redirects (see Configuration).

## Operation
- States: IDLE, FETCH, HALTED.
  - IDLE → FETCH after one cycle.
  - FETCH → HALTED when an accepted word has inst[15:12] == `HALT_OP`.
  - HALTED → FETCH only on `redirect_valid`.
  - Any state → IDLE on `reset`.
- `imem_req` = (state == FETCH) && count < 2.
- Fetch accept = `imem_req` && `imem_ack` && !`redirect_valid`. On accept:
  - push {pc, imem_rdata} into the queue;
  - `next_pc` = pc + 1, modulo 2^16 (0xFFFF wraps to 0x0000).
- In any other cycle without a redirect, `next_pc` = `pc` (hold).
- Pop = `inst_valid` && `inst_ready` && !`redirect_valid`.
- Redirect has top priority:
  - `next_pc` = `redirect_target`;
  - queue cleared to count 0;
  - any `imem_ack` in that cycle is dropped;
  - the pop in that cycle does not happen.
- Push and pop in the same cycle: count unchanged, FIFO order preserved.
- The halt word itself is enqueued and delivered to decode. `next_pc` holds at the halt address + 1.
- `inst_valid` = count != 0. `inst` and `inst_pc` are the head entry and are 0 when empty.

## Timing
- Reset values:
  - state IDLE, count 0;
  - `imem_req` 0, `inst_valid` 0;
  - `inst` 0, `inst_pc` 0;
  - `next_pc` 0, counters 0.
- `next_pc` is combinational from `pc`, `imem_ack` and redirect inputs. It is sampled by the program counter register at the same edge as the internal state.
- Latency: a word acked in cycle N appears on `inst`/`inst_valid` in cycle N+1.
- Throughput: 1 instruction/cycle with zero-wait memory and `inst_ready` held high.
- Redirect in cycle N:
  - `pc` = target in N+1;
  - first target instruction on `inst` no earlier than N+2.
- Reset mid-operation: queue contents lost; the first request is issued at PC 0 on the second cycle after `reset` falls.

## Configuration
- `FETCH_PERF_EN` defined:
  - `fetch_count` increments per accept;
  - `flush_count` adds the queue count discarded at each redirect;
  - both wrap at 16 bits and clear on `reset`.
- `FETCH_PERF_EN` undefined: both ports present, tied to 0, and no counter flops.

## Structure
- `fetch_pkg` holds:
  - state enum `fetch_state_t` (IDLE, FETCH, HALTED);
  - `FETCH_Q_DEPTH` = 2;
  - the default halt opcode;
  - the queue entry struct {pc, inst}.
- Sub-module `fetch_queue`: 2-entry synchronous FIFO with push, pop, flush, count, head. Flush overrides push and pop.
- The FSM, request logic and `next_pc` mux live in `fetch_unit`.

## Test plan
- Zero-wait memory returning addr XOR 0x1000, `inst_ready`=1, after reset:
  - `inst_pc` sequence is 0,1,2,3 on consecutive cycles;
  - `inst` = 0x1000, 0x1001, …
- `imem_ack` low for 3 cycles at PC 5: `next_pc` holds at 5 for those cycles; advances to 6 on the ack.
- `inst_ready`=0 for 4 cycles: queue fills to 2, `imem_req` drops, `pc` frozen. Release: entries drain in order and fetch resumes.
- Queue holding PC 7,8 with redirect to 0x0040 and a simultaneous ack:
  - queue empties and the ack is dropped;
  - next `inst_pc` = 0x0040;
  - `flush_count` +2 with `FETCH_PERF_EN`.
- Memory returns 0xF123 at PC 0x0010:
  - that word is delivered;
  - state HALTED, `imem_req` 0, `pc` stays 0x0011;
  - a redirect to 0 resumes fetching.
- PC at 0xFFFF accepted → `next_pc` 0x0000. Assert `reset` mid-stream → all outputs at reset values on the next cycle.
